// File: rtl/dcache_miss_handler.sv
// dcache_miss_handler: port-A miss/refill engine for the 2-way data cache.
// Chooses a victim way, writes it back when dirty, refills the line over a
// Wishbone incrementing burst, installs data/tag/clean dirty-bit and keeps
// the per-set LRU bits.
module dcache_miss_handler #(
  parameter int INDEX_W    = 7,
  parameter int TAG_W      = 20,
  parameter int LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_req,
  input  logic [31:0]              miss_paddr,
  output logic                     miss_busy,
  output logic                     miss_done,
  output logic                     miss_err,
  input  logic                     hit_upd,
  input  logic [INDEX_W-1:0]       hit_index,
  input  logic                     hit_way,
  output logic [INDEX_W-1:0]       arr_index,
  input  logic [31:0]              tag_w0_i,
  input  logic [31:0]              tag_w1_i,
  input  logic                     dirty_w0_i,
  input  logic                     dirty_w1_i,
  input  logic [LINE_WORDS*32-1:0] data_w0_i,
  input  logic [LINE_WORDS*32-1:0] data_w1_i,
  output logic [LINE_WORDS*4-1:0]  we_w0,
  output logic [LINE_WORDS*4-1:0]  we_w1,
  output logic [LINE_WORDS*32-1:0] line_o,
  output logic [3:0]               we_tag_w0,
  output logic [3:0]               we_tag_w1,
  output logic [31:0]              tag_o,
  output logic                     dirty_we_w0,
  output logic                     dirty_we_w1,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_rty_i,
  input  logic [31:0]              wb_dat_i,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [31:0]              wb_adr_o,
  output logic [31:0]              wb_dat_o,
  output logic [3:0]               wb_sel_o,
  output logic [2:0]               wb_cti_o,
  output logic [1:0]               wb_bte_o
);

  localparam int OFF_W     = $clog2(LINE_WORDS * 4);
  localparam int BEAT_W    = $clog2(LINE_WORDS);
  localparam int LINE_W    = LINE_WORDS * 32;
  localparam int VALID_BIT = 22;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_META, S_LATCH, S_WB_BURST, S_WB_GAP, S_RF_BURST, S_WRITE_LINE, S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [BEAT_W-1:0]      r_beat;
  logic                   r_err;
  logic [(1<<INDEX_W)-1:0] r_lru;
  logic [31:0]            r_paddr;
  logic                   r_victim;
  logic [TAG_W-1:0]       r_vtag;
  logic [LINE_W-1:0]      r_vdata;
  logic [LINE_W-1:0]      r_line;

  logic [INDEX_W-1:0]     w_index;
  logic                   w_in_burst;
  logic                   w_beat_ok;
  logic                   w_victim;
  logic                   w_vvalid;
  logic                   w_vdirty;
  logic [BEAT_W+4:0]      w_word_lsb;
  logic [31:0]            w_tag_word;
  logic                   w_unused;

  assign w_index    = r_paddr[OFF_W +: INDEX_W];
  assign w_in_burst = (r_state == S_WB_BURST) || (r_state == S_RF_BURST);
  // A beat completes only on a clean ack; retry and error both leave it pending.
  assign w_beat_ok  = wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign w_word_lsb = {r_beat, 5'd0};
  assign w_tag_word = {{(31-VALID_BIT){1'b0}}, 1'b1, {(VALID_BIT-TAG_W){1'b0}},
                       r_paddr[31 -: TAG_W]};

  // Invalid ways are filled first (way 0 preferred); only a full set consults LRU.
  assign w_victim = !tag_w0_i[VALID_BIT] ? 1'b0 :
                    !tag_w1_i[VALID_BIT] ? 1'b1 : r_lru[w_index];
  assign w_vvalid = w_victim ? tag_w1_i[VALID_BIT] : tag_w0_i[VALID_BIT];
  assign w_vdirty = w_victim ? dirty_w1_i : dirty_w0_i;

  assign w_unused = ^{tag_w0_i[31:VALID_BIT+1], tag_w0_i[VALID_BIT-1:TAG_W],
                      tag_w1_i[31:VALID_BIT+1], tag_w1_i[VALID_BIT-1:TAG_W],
                      r_paddr[OFF_W-1:0]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (miss_req) w_next = S_RD_META;
      S_RD_META:    w_next = S_LATCH;
      S_LATCH:      w_next = (w_vvalid && w_vdirty) ? S_WB_BURST : S_RF_BURST;
      S_WB_BURST: begin
        if (wb_err_i)                             w_next = S_IDLE;
        else if (w_beat_ok && r_beat == LAST_BEAT) w_next = S_WB_GAP;
      end
      S_WB_GAP:     w_next = S_RF_BURST;
      S_RF_BURST: begin
        if (wb_err_i)                             w_next = S_IDLE;
        else if (w_beat_ok && r_beat == LAST_BEAT) w_next = S_WRITE_LINE;
      end
      S_WRITE_LINE: w_next = S_DONE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so an async reset clears them at once.
  always_comb begin
    miss_busy   = (r_state != S_IDLE);
    miss_done   = (r_state == S_DONE);
    miss_err    = r_err;
    arr_index   = '0;
    we_w0       = '0;
    we_w1       = '0;
    line_o      = '0;
    we_tag_w0   = 4'h0;
    we_tag_w1   = 4'h0;
    tag_o       = '0;
    dirty_we_w0 = 1'b0;
    dirty_we_w1 = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_adr_o    = '0;
    wb_dat_o    = '0;
    wb_sel_o    = 4'h0;
    wb_cti_o    = 3'b000;
    wb_bte_o    = 2'b00;
    case (r_state)
      S_RD_META: arr_index = w_index;
      S_WB_BURST, S_RF_BURST: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_sel_o = 4'hF;
        wb_cti_o = (r_beat == LAST_BEAT) ? 3'b111 : 3'b010;
        if (r_state == S_WB_BURST) begin
          wb_we_o  = 1'b1;
          wb_adr_o = {r_vtag, w_index, r_beat, 2'b00};
          wb_dat_o = r_vdata[w_word_lsb +: 32];
        end else begin
          wb_adr_o = {r_paddr[31:OFF_W], r_beat, 2'b00};
        end
      end
      S_WRITE_LINE: begin
        arr_index = w_index;
        line_o    = r_line;
        tag_o     = w_tag_word;
        if (r_victim) begin
          we_w1       = '1;
          we_tag_w1   = 4'hF;
          dirty_we_w1 = 1'b1;
        end else begin
          we_w0       = '1;
          we_tag_w0   = 4'hF;
          dirty_we_w0 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Beat counter and the one-cycle error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_in_burst & wb_err_i;
      if (w_in_burst) begin
        if (wb_err_i)       r_beat <= '0;
        else if (w_beat_ok) r_beat <= r_beat + 1'b1;
      end
    end
  end

  // LRU bits; the refill update is written last so it beats a same-index hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lru <= '0;
    end else begin
      if (hit_upd)                   r_lru[hit_index] <= ~hit_way;
      if (r_state == S_WRITE_LINE)   r_lru[w_index]   <= ~r_victim;
    end
  end

  // Miss address, victim metadata/data and the refill line buffer.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && miss_req) r_paddr <= miss_paddr;
    if (r_state == S_LATCH) begin
      r_victim <= w_victim;
      r_vtag   <= w_victim ? tag_w1_i[TAG_W-1:0] : tag_w0_i[TAG_W-1:0];
      r_vdata  <= w_victim ? data_w1_i : data_w0_i;
    end
    if (r_state == S_RF_BURST && w_beat_ok) r_line[w_word_lsb +: 32] <= wb_dat_i;
  end

endmodule

// File: tb/tb_dcache_miss_handler.sv
// tb_dcache_miss_handler: directed scenarios for the data-cache miss handler,
// with a small Wishbone slave that can insert waits, a retry or an error.
module tb_dcache_miss_handler;

  localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

  logic         clk, rst;
  logic         miss_req;
  logic [31:0]  miss_paddr;
  logic         miss_busy, miss_done, miss_err;
  logic         hit_upd;
  logic [6:0]   hit_index;
  logic         hit_way;
  logic [6:0]   arr_index;
  logic [31:0]  tag_w0_i, tag_w1_i;
  logic         dirty_w0_i, dirty_w1_i;
  logic [255:0] data_w0_i, data_w1_i;
  logic [31:0]  we_w0, we_w1;
  logic [255:0] line_o;
  logic [3:0]   we_tag_w0, we_tag_w1;
  logic [31:0]  tag_o;
  logic         dirty_we_w0, dirty_we_w1;
  logic         wb_ack_i, wb_err_i, wb_rty_i;
  logic [31:0]  wb_dat_i;
  logic         wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]  wb_adr_o, wb_dat_o;
  logic [3:0]   wb_sel_o;
  logic [2:0]   wb_cti_o;
  logic [1:0]   wb_bte_o;
  logic         any_out;

  dcache_miss_handler dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_paddr(miss_paddr),
    .miss_busy(miss_busy), .miss_done(miss_done), .miss_err(miss_err),
    .hit_upd(hit_upd), .hit_index(hit_index), .hit_way(hit_way),
    .arr_index(arr_index), .tag_w0_i(tag_w0_i), .tag_w1_i(tag_w1_i),
    .dirty_w0_i(dirty_w0_i), .dirty_w1_i(dirty_w1_i),
    .data_w0_i(data_w0_i), .data_w1_i(data_w1_i),
    .we_w0(we_w0), .we_w1(we_w1), .line_o(line_o),
    .we_tag_w0(we_tag_w0), .we_tag_w1(we_tag_w1), .tag_o(tag_o),
    .dirty_we_w0(dirty_we_w0), .dirty_we_w1(dirty_we_w1),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o)
  );

  assign any_out = |{miss_busy, miss_done, miss_err, arr_index, we_w0, we_w1, line_o,
                     we_tag_w0, we_tag_w1, tag_o, dirty_we_w0, dirty_we_w1,
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
                     wb_cti_o, wb_bte_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Slave / scenario configuration
  int cfg_wait_beat, cfg_wait_n, cfg_rty_beat, cfg_err_beat;
  int cfg_hit_cyc, cfg_req_cyc, cfg_rst_cyc;
  logic [6:0] cfg_hit_idx;
  logic       cfg_hit_way;

  // Observations from one miss
  int done_cyc, err_cyc, wl_cyc, wl_cnt, rd_n, wr_n, held_bad, bad_sel, gap_n;
  int first_rd_cyc, first_wr_cyc, last_wr_cyc;
  logic cyc_at_err, busy_c1, rst_pre, rst_outs;
  logic [6:0]   idx_c1;
  logic [31:0]  rd_adr [8];
  logic [2:0]   rd_cti [8];
  logic [31:0]  wr_adr [8];
  logic [31:0]  wr_dat [8];
  logic [2:0]   wr_cti [8];
  logic [31:0]  cap_we0, cap_we1, cap_tag;
  logic [3:0]   cap_tw0, cap_tw1;
  logic         cap_d0, cap_d1;
  logic [255:0] cap_line;

  task automatic cfg_clear();
    cfg_wait_beat = -1; cfg_wait_n = 0; cfg_rty_beat = -1; cfg_err_beat = -1;
    cfg_hit_cyc = -1; cfg_req_cyc = -1; cfg_rst_cyc = -1;
    cfg_hit_idx = '0; cfg_hit_way = 1'b0;
  endtask

  task automatic set_arr(input logic v0, input logic [19:0] t0, input logic d0,
                         input logic v1, input logic [19:0] t1, input logic d1);
    tag_w0_i = {9'b0, v0, 2'b00, t0};
    tag_w1_i = {9'b0, v1, 2'b00, t1};
    dirty_w0_i = d0;
    dirty_w1_i = d1;
    for (int i = 0; i < 8; i++) begin
      data_w0_i[i*32 +: 32] = 32'h2222_0000 + i;
      data_w1_i[i*32 +: 32] = 32'h1111_0000 + i;
    end
  endtask

  task automatic do_hit(input logic [6:0] idx, input logic way);
    hit_upd = 1'b1; hit_index = idx; hit_way = way;
    @(posedge clk); #1;
    hit_upd = 1'b0;
  endtask

  // Issue one miss at cycle T and act as the Wishbone slave until done/err.
  task automatic run_miss(input logic [31:0] pa, input int budget);
    int sbeat, waits;
    bit rtyd, pend;
    logic [31:0] padr;
    sbeat = 0; waits = 0; rtyd = 0; pend = 0; padr = '0;
    done_cyc = 0; err_cyc = 0; wl_cyc = 0; wl_cnt = 0; rd_n = 0; wr_n = 0;
    held_bad = 0; bad_sel = 0; gap_n = 0; first_rd_cyc = 0; first_wr_cyc = 0; last_wr_cyc = 0;
    cyc_at_err = 1'bx; busy_c1 = 1'b0; idx_c1 = '0; rst_pre = 1'b0; rst_outs = 1'b1;
    cap_we0 = '0; cap_we1 = '0; cap_tag = '0; cap_tw0 = '0; cap_tw1 = '0;
    cap_d0 = 1'b0; cap_d1 = 1'b0; cap_line = '0;
    for (int i = 0; i < 8; i++) begin
      rd_adr[i] = '0; rd_cti[i] = '0; wr_adr[i] = '0; wr_dat[i] = '0; wr_cti[i] = '0;
    end
    miss_paddr = pa; miss_req = 1'b1;
    @(posedge clk); #1;
    miss_paddr = 32'hDEAD_BEEF;
    for (int c = 1; c <= budget; c++) begin
      miss_req = 1'b0; hit_upd = 1'b0;
      wb_ack_i = 1'b0; wb_rty_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
      if (c == cfg_rst_cyc) begin
        rst_pre = wb_cyc_o;
        rst = 1'b1;
        #1;
        rst_outs = any_out;
        break;
      end
      if (c == 1) begin idx_c1 = arr_index; busy_c1 = miss_busy; end
      if (miss_done) done_cyc = c;
      if (miss_err) begin err_cyc = c; cyc_at_err = wb_cyc_o; end
      if ((we_w0 | we_w1) != 0 || (we_tag_w0 | we_tag_w1) != 0 || dirty_we_w0 || dirty_we_w1) begin
        wl_cnt++; wl_cyc = c;
        cap_we0 = we_w0; cap_we1 = we_w1; cap_tw0 = we_tag_w0; cap_tw1 = we_tag_w1;
        cap_d0 = dirty_we_w0; cap_d1 = dirty_we_w1; cap_tag = tag_o; cap_line = line_o;
      end
      if (wb_cyc_o) begin
        if (wb_sel_o !== 4'hF || wb_bte_o !== 2'b00 || wb_stb_o !== 1'b1) bad_sel++;
        if (pend && wb_adr_o !== padr) held_bad++;
        if (!wb_we_o && sbeat == cfg_err_beat) begin
          wb_err_i = 1'b1; pend = 0;
        end else if (!wb_we_o && sbeat == cfg_wait_beat && waits < cfg_wait_n) begin
          waits++; pend = 1; padr = wb_adr_o;
        end else if (!wb_we_o && sbeat == cfg_rty_beat && !rtyd) begin
          rtyd = 1; wb_rty_i = 1'b1; pend = 1; padr = wb_adr_o;
        end else begin
          wb_ack_i = 1'b1; pend = 0;
          if (wb_we_o) begin
            if (wr_n == 0) first_wr_cyc = c;
            if (wr_n < 8) begin wr_adr[wr_n] = wb_adr_o; wr_dat[wr_n] = wb_dat_o; wr_cti[wr_n] = wb_cti_o; end
            wr_n++; last_wr_cyc = c;
          end else begin
            wb_dat_i = wb_adr_o ^ RD_KEY;
            if (rd_n == 0) first_rd_cyc = c;
            if (rd_n < 8) begin rd_adr[rd_n] = wb_adr_o; rd_cti[rd_n] = wb_cti_o; end
            rd_n++;
          end
          sbeat = (sbeat == 7) ? 0 : sbeat + 1;
        end
      end else if (miss_busy && wr_n == 8 && rd_n == 0) begin
        gap_n++;
      end
      if (c == cfg_hit_cyc) begin hit_upd = 1'b1; hit_index = cfg_hit_idx; hit_way = cfg_hit_way; end
      if (c == cfg_req_cyc) begin miss_req = 1'b1; miss_paddr = 32'hFFFF_FFE0; end
      if (done_cyc > 0 || err_cyc > 0) break;
      @(posedge clk); #1;
    end
    miss_req = 1'b0; hit_upd = 1'b0;
    wb_ack_i = 1'b0; wb_rty_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    miss_req = 1'b0; miss_paddr = '0; hit_upd = 1'b0; hit_index = '0; hit_way = 1'b0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
    set_arr(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0);
    cfg_clear();
    repeat (2) @(posedge clk);
    #1;
    total++; if (any_out !== 1'b0) $display("FAIL reset_outputs: got %b want 0", any_out); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (any_out !== 1'b0) $display("FAIL idle_outputs: got %b want 0", any_out); else passed++;
  endtask

  task automatic test_clean_miss();
    logic [31:0] exp;
    set_arr(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0);
    cfg_clear();
    run_miss(32'h0000_1A40, 40);
    total++; if (idx_c1 !== 7'h52) $display("FAIL clean_arr_index: got %h want 52", idx_c1); else passed++;
    total++; if (busy_c1 !== 1'b1) $display("FAIL clean_busy: got %b want 1", busy_c1); else passed++;
    total++; if (rd_n !== 8 || wr_n !== 0) $display("FAIL clean_beats: got rd %0d wr %0d want 8 0", rd_n, wr_n); else passed++;
    total++; if (first_rd_cyc !== 3) $display("FAIL clean_first_ack: got %0d want 3", first_rd_cyc); else passed++;
    for (int i = 0; i < 8; i++) begin
      exp = 32'h0000_1A40 + 4 * i;
      total++; if (rd_adr[i] !== exp) $display("FAIL clean_adr%0d: got %h want %h", i, rd_adr[i], exp); else passed++;
    end
    total++; if (rd_cti[0] !== 3'b010 || rd_cti[6] !== 3'b010 || rd_cti[7] !== 3'b111)
      $display("FAIL clean_cti: got %b %b %b want 010 010 111", rd_cti[0], rd_cti[6], rd_cti[7]); else passed++;
    total++; if (bad_sel !== 0) $display("FAIL clean_sel_bte: got %0d bad cycles want 0", bad_sel); else passed++;
    total++; if (wl_cyc !== 11 || wl_cnt !== 1) $display("FAIL clean_wl: got cyc %0d cnt %0d want 11 1", wl_cyc, wl_cnt); else passed++;
    total++; if (cap_we0 !== 32'hFFFF_FFFF || cap_we1 !== 32'h0) $display("FAIL clean_we: got %h %h want ffffffff 0", cap_we0, cap_we1); else passed++;
    total++; if (cap_tw0 !== 4'hF || cap_tw1 !== 4'h0) $display("FAIL clean_we_tag: got %h %h want f 0", cap_tw0, cap_tw1); else passed++;
    total++; if (cap_tag !== 32'h0040_0001) $display("FAIL clean_tag_o: got %h want 00400001", cap_tag); else passed++;
    total++; if (cap_d0 !== 1'b1 || cap_d1 !== 1'b0) $display("FAIL clean_dirty_we: got %b %b want 1 0", cap_d0, cap_d1); else passed++;
    for (int i = 0; i < 8; i++) begin
      exp = (32'h0000_1A40 + 4 * i) ^ RD_KEY;
      total++; if (cap_line[i*32 +: 32] !== exp) $display("FAIL clean_line%0d: got %h want %h", i, cap_line[i*32 +: 32], exp); else passed++;
    end
    total++; if (done_cyc !== 12) $display("FAIL clean_done: got %0d want 12", done_cyc); else passed++;
    @(posedge clk); #1;
    // Full set at index 0x52: victim must be the LRU way, now way 1.
    set_arr(1'b1, 20'h11111, 1'b0, 1'b1, 20'h22222, 1'b0);
    run_miss(32'h0000_1A40, 40);
    total++; if (cap_we1 !== 32'hFFFF_FFFF || cap_we0 !== 32'h0) $display("FAIL clean_lru52: got we0 %h we1 %h want 0 ffffffff", cap_we0, cap_we1); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_dirty_miss();
    logic [31:0] exp;
    cfg_clear();
    do_hit(7'd5, 1'b0);
    set_arr(1'b1, 20'h0AAAA, 1'b0, 1'b1, 20'h12345, 1'b1);
    run_miss(32'h0ABC_D0A0, 60);
    total++; if (wr_n !== 8) $display("FAIL dirty_wr_beats: got %0d want 8", wr_n); else passed++;
    total++; if (first_wr_cyc !== 3 || last_wr_cyc !== 10) $display("FAIL dirty_wr_cycles: got %0d..%0d want 3..10", first_wr_cyc, last_wr_cyc); else passed++;
    for (int i = 0; i < 8; i++) begin
      exp = 32'h1234_50A0 + 4 * i;
      total++; if (wr_adr[i] !== exp) $display("FAIL dirty_wadr%0d: got %h want %h", i, wr_adr[i], exp); else passed++;
      exp = 32'h1111_0000 + i;
      total++; if (wr_dat[i] !== exp) $display("FAIL dirty_wdat%0d: got %h want %h", i, wr_dat[i], exp); else passed++;
    end
    total++; if (wr_cti[0] !== 3'b010 || wr_cti[6] !== 3'b010 || wr_cti[7] !== 3'b111)
      $display("FAIL dirty_cti: got %b %b %b want 010 010 111", wr_cti[0], wr_cti[6], wr_cti[7]); else passed++;
    total++; if (gap_n !== 1) $display("FAIL dirty_gap: got %0d want 1", gap_n); else passed++;
    total++; if (first_rd_cyc !== 12 || rd_n !== 8) $display("FAIL dirty_refill: got start %0d beats %0d want 12 8", first_rd_cyc, rd_n); else passed++;
    total++; if (rd_adr[0] !== 32'h0ABC_D0A0 || rd_adr[7] !== 32'h0ABC_D0BC) $display("FAIL dirty_radr: got %h %h want 0abcd0a0 0abcd0bc", rd_adr[0], rd_adr[7]); else passed++;
    total++; if (wl_cyc !== 20) $display("FAIL dirty_wl_cyc: got %0d want 20", wl_cyc); else passed++;
    total++; if (cap_we1 !== 32'hFFFF_FFFF || cap_we0 !== 32'h0 || cap_d1 !== 1'b1 || cap_d0 !== 1'b0)
      $display("FAIL dirty_way1_write: got we %h %h dirty %b %b want 0 ffffffff 0 1", cap_we0, cap_we1, cap_d0, cap_d1); else passed++;
    total++; if (cap_tag !== 32'h0040_ABCD) $display("FAIL dirty_tag_o: got %h want 0040abcd", cap_tag); else passed++;
    total++; if (done_cyc !== 21) $display("FAIL dirty_done: got %0d want 21", done_cyc); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_wait_retry();
    logic [31:0] exp;
    cfg_clear();
    cfg_wait_beat = 3; cfg_wait_n = 2; cfg_rty_beat = 6;
    set_arr(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0);
    run_miss(32'h0000_3F80, 60);
    total++; if (held_bad !== 0) $display("FAIL stall_adr_held: got %0d changes want 0", held_bad); else passed++;
    total++; if (rd_n !== 8) $display("FAIL stall_beats: got %0d want 8", rd_n); else passed++;
    total++; if (rd_adr[3] !== 32'h0000_3F8C || rd_adr[6] !== 32'h0000_3F98) $display("FAIL stall_adr: got %h %h want 3f8c 3f98", rd_adr[3], rd_adr[6]); else passed++;
    total++; if (wl_cyc !== 14) $display("FAIL stall_wl_cyc: got %0d want 14", wl_cyc); else passed++;
    total++; if (done_cyc !== 15) $display("FAIL stall_done: got %0d want 15", done_cyc); else passed++;
    for (int i = 0; i < 8; i++) begin
      exp = (32'h0000_3F80 + 4 * i) ^ RD_KEY;
      total++; if (cap_line[i*32 +: 32] !== exp) $display("FAIL stall_line%0d: got %h want %h", i, cap_line[i*32 +: 32], exp); else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bus_error();
    cfg_clear();
    cfg_err_beat = 4;
    set_arr(1'b1, 20'h33333, 1'b0, 1'b1, 20'h44444, 1'b0);
    run_miss(32'h0000_0460, 40);
    total++; if (rd_n !== 4) $display("FAIL err_beats: got %0d want 4", rd_n); else passed++;
    total++; if (err_cyc !== 8) $display("FAIL err_pulse_cyc: got %0d want 8", err_cyc); else passed++;
    total++; if (cyc_at_err !== 1'b0) $display("FAIL err_cyc_drop: got %b want 0", cyc_at_err); else passed++;
    total++; if (wl_cnt !== 0 || done_cyc !== 0) $display("FAIL err_no_write: got writes %0d done %0d want 0 0", wl_cnt, done_cyc); else passed++;
    @(posedge clk); #1;
    total++; if (miss_err !== 1'b0 || miss_busy !== 1'b0) $display("FAIL err_one_cycle: got err %b busy %b want 0 0", miss_err, miss_busy); else passed++;
    cfg_clear();
    run_miss(32'h0000_0460, 40);
    total++; if (cap_we0 !== 32'hFFFF_FFFF || cap_we1 !== 32'h0) $display("FAIL err_lru_kept: got we0 %h we1 %h want ffffffff 0", cap_we0, cap_we1); else passed++;
    total++; if (done_cyc !== 12) $display("FAIL err_retry_done: got %0d want 12", done_cyc); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_hit_collision();
    cfg_clear();
    cfg_hit_cyc = 11; cfg_hit_idx = 7'h10; cfg_hit_way = 1'b0; cfg_req_cyc = 5;
    set_arr(1'b1, 20'h55555, 1'b0, 1'b0, 20'h0, 1'b0);
    run_miss(32'h0000_0200, 40);
    total++; if (cap_we1 !== 32'hFFFF_FFFF || cap_we0 !== 32'h0) $display("FAIL coll_victim: got we0 %h we1 %h want 0 ffffffff", cap_we0, cap_we1); else passed++;
    total++; if (rd_adr[7] !== 32'h0000_021C) $display("FAIL coll_paddr_kept: got %h want 0000021c", rd_adr[7]); else passed++;
    total++; if (done_cyc !== 12) $display("FAIL coll_done: got %0d want 12", done_cyc); else passed++;
    @(posedge clk); #1;
    total++; if (miss_busy !== 1'b0) $display("FAIL coll_req_ignored: got busy %b want 0", miss_busy); else passed++;
    cfg_clear();
    set_arr(1'b1, 20'h55555, 1'b0, 1'b1, 20'h66666, 1'b0);
    run_miss(32'h0000_0200, 40);
    total++; if (cap_we0 !== 32'hFFFF_FFFF || cap_we1 !== 32'h0) $display("FAIL coll_refill_wins: got we0 %h we1 %h want ffffffff 0", cap_we0, cap_we1); else passed++;
    @(posedge clk); #1;
    // That refill pointed LRU[0x10] at way 1; a lone hit on way 1 points it back.
    do_hit(7'h10, 1'b1);
    run_miss(32'h0000_0200, 40);
    total++; if (cap_we0 !== 32'hFFFF_FFFF || cap_we1 !== 32'h0) $display("FAIL hit_upd_lru: got we0 %h we1 %h want ffffffff 0", cap_we0, cap_we1); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midburst();
    cfg_clear();
    cfg_rst_cyc = 8;
    set_arr(1'b1, 20'h12345, 1'b1, 1'b1, 20'h0AAAA, 1'b0);
    run_miss(32'h0ABC_D0A0, 40);
    total++; if (rst_pre !== 1'b1 || wr_n !== 5) $display("FAIL rst_in_burst: got cyc %b beats %0d want 1 5", rst_pre, wr_n); else passed++;
    total++; if (rst_outs !== 1'b0) $display("FAIL rst_async_outputs: got %b want 0", rst_outs); else passed++;
    total++; if (wl_cnt !== 0) $display("FAIL rst_no_write: got %0d want 0", wl_cnt); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cfg_clear();
    set_arr(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0);
    run_miss(32'h0000_1A40, 40);
    total++; if (idx_c1 !== 7'h52 || busy_c1 !== 1'b1) $display("FAIL rst_restart_meta: got idx %h busy %b want 52 1", idx_c1, busy_c1); else passed++;
    total++; if (first_rd_cyc !== 3 || rd_adr[0] !== 32'h0000_1A40) $display("FAIL rst_restart_burst: got cyc %0d adr %h want 3 00001a40", first_rd_cyc, rd_adr[0]); else passed++;
    total++; if (done_cyc !== 12) $display("FAIL rst_restart_done: got %0d want 12", done_cyc); else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_wait_retry();
    test_bus_error();
    test_hit_collision();
    test_reset_midburst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
